// File: rtl/asip_prog_sequencer_if.sv
// Byte-stream program load port between a loader and the sequencer.
// The source drives valid/data/last; the sequencer answers with ready.
interface asip_prog_sequencer_if #(
  parameter int LOAD_W = 8
);
  logic              load_valid;
  logic              load_ready;
  logic [LOAD_W-1:0] load_data;
  logic              load_last;

  modport master (
    output load_valid,
    output load_data,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_last,
    output load_ready
  );
endinterface

// File: rtl/asip_prog_sequencer.sv
// Program loader and instruction sequencer for the single-cycle ASIP core.
// Packs load bytes into words, then feeds instr from pc until halt.
module asip_prog_sequencer #(
  parameter int                  INSTR_W    = 17,
  parameter int                  PC_W       = 17,
  parameter int                  DEPTH      = 256,
  parameter int                  ADDR_W     = 8,
  parameter int                  LOAD_W     = 8,
  parameter logic [INSTR_W-1:0]  NOP_INSTR  = 17'h00000,
  parameter logic [INSTR_W-1:0]  HALT_INSTR = 17'h1FFFF,
  parameter int                  CNT_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  asip_prog_sequencer_if.slave ld,
  input  logic                clear,
  input  logic                start,
  input  logic [PC_W-1:0]     pc,
  output logic [INSTR_W-1:0]  instr,
  output logic                cpu_reset,
  output logic                halted,
  output logic [ADDR_W:0]     prog_len,
  output logic [CNT_W-1:0]    cycle_count,
  output logic                err_overflow,
  output logic                err_pc
);

  localparam int BPW = (INSTR_W + LOAD_W - 1) / LOAD_W;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int CW  = (PC_W > ADDR_W + 1) ? PC_W : ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, READY, RUN, HALT
  } state_t;

  state_t state, state_n;

  logic [INSTR_W-1:0] store [DEPTH];
  logic [INSTR_W-1:0] acc, nxt_acc, rd_word;
  logic [BIW-1:0]     bidx;
  logic [CW-1:0]      pc_x, len_x;
  logic               xfer, word_done, full;
  logic               in_range, halt_now, go;

  assign ld.load_ready = (state == IDLE) || (state == LOAD);
  assign xfer      = ld.load_valid && ld.load_ready;
  assign word_done = xfer && (bidx == BIW'(BPW - 1) || ld.load_last);
  assign full      = prog_len == (ADDR_W + 1)'(DEPTH);

  assign pc_x     = CW'(pc);
  assign len_x    = CW'(prog_len);
  assign in_range = pc_x < len_x;
  assign rd_word  = store[pc[ADDR_W-1:0]];

  assign instr = (state != RUN) ? NOP_INSTR :
                 in_range ? rd_word : HALT_INSTR;
  assign halt_now  = (state == RUN) && (instr == HALT_INSTR);
  assign go        = start && (state == READY || state == HALT);
  assign cpu_reset = state != RUN;
  assign halted    = state == HALT;

  // Bits past INSTR_W in the top byte simply have no home and drop out.
  always_comb begin
    nxt_acc = acc;
    for (int b = 0; b < INSTR_W; b++) begin
      if (BIW'(b / LOAD_W) == bidx) nxt_acc[b] = ld.load_data[b % LOAD_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (xfer) state_n = ld.load_last ? READY : LOAD;
      LOAD:  if (xfer && ld.load_last) state_n = READY;
      READY: if (start) state_n = RUN;
      RUN:   if (halt_now) state_n = HALT;
      HALT:  if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
    if (clear) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc          <= '0;
      bidx         <= '0;
      prog_len     <= '0;
      cycle_count  <= '0;
      err_overflow <= 1'b0;
      err_pc       <= 1'b0;
    end else if (clear) begin
      acc          <= '0;
      bidx         <= '0;
      prog_len     <= '0;
      err_overflow <= 1'b0;
      err_pc       <= 1'b0;
    end else begin
      if (word_done) begin
        acc  <= '0;
        bidx <= '0;
        if (full) err_overflow <= 1'b1;
        else      prog_len     <= prog_len + 1'b1;
      end else if (xfer) begin
        acc  <= nxt_acc;
        bidx <= bidx + 1'b1;
      end
      if (go) cycle_count <= '0;
      else if (state == RUN && cycle_count != '1)
        cycle_count <= cycle_count + 1'b1;
      if (halt_now && !in_range) err_pc <= 1'b1;
    end
  end

  // Store is deliberately not reset; only prog_len bounds what is valid.
  always_ff @(posedge clk) begin
    if (word_done && !full && !clear)
      store[prog_len[ADDR_W-1:0]] <= nxt_acc;
  end

endmodule

// File: tb/tb_asip_prog_sequencer.sv
// Self-checking bench for asip_prog_sequencer.
// Expected instr words are queued as pc is driven and popped on compare.
module tb_asip_prog_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  asip_prog_sequencer_if #(.LOAD_W(8)) lb ();
  asip_prog_sequencer_if #(.LOAD_W(8)) lb4 ();

  logic        clear, start, clear4, start4;
  logic [16:0] pc, pc4, instr, instr4;
  logic        cpu_reset, halted, err_overflow, err_pc;
  logic        cpu_reset4, halted4, err_overflow4, err_pc4;
  logic [8:0]  prog_len;
  logic [2:0]  prog_len4;
  logic [31:0] cycle_count, cycle_count4;

  asip_prog_sequencer u_dut (
    .clk(clk), .reset(reset), .ld(lb.slave),
    .clear(clear), .start(start), .pc(pc), .instr(instr),
    .cpu_reset(cpu_reset), .halted(halted), .prog_len(prog_len),
    .cycle_count(cycle_count), .err_overflow(err_overflow),
    .err_pc(err_pc)
  );

  asip_prog_sequencer #(.DEPTH(4), .ADDR_W(2)) u_d4 (
    .clk(clk), .reset(reset), .ld(lb4.slave),
    .clear(clear4), .start(start4), .pc(pc4), .instr(instr4),
    .cpu_reset(cpu_reset4), .halted(halted4), .prog_len(prog_len4),
    .cycle_count(cycle_count4), .err_overflow(err_overflow4),
    .err_pc(err_pc4)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [16:0] q [$];
  logic [16:0] e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    lb.load_valid = 1'b1;
    lb.load_data  = d;
    lb.load_last  = last;
    tick();
    lb.load_valid = 1'b0;
    lb.load_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic load_prog1();
    send(8'hEF, 0); send(8'h1F, 0); send(8'h00, 0);
    send(8'h00, 0); send(8'hEE, 0); send(8'h01, 0);
    send(8'hFF, 0); send(8'hFF, 0); send(8'h01, 1);
  endtask

  task automatic test_reset();
    tick(); tick();
    vectors++;
    if ({lb.load_ready, cpu_reset, halted, err_overflow, err_pc}
        !== 5'b11000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 11000",
               {lb.load_ready, cpu_reset, halted, err_overflow, err_pc});
    end
    vectors++;
    if (instr !== 17'h0 || prog_len !== 9'd0 || cycle_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_vals: instr=%h len=%0d cnt=%0d want 0/0/0",
               instr, prog_len, cycle_count);
    end
    vectors++;
    if (lb4.load_ready !== 1'b1 || prog_len4 !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_d4: ready=%b len=%0d want 1/0",
               lb4.load_ready, prog_len4);
    end
    reset = 1'b1;
    tick();
    pulse_start();
    vectors++;
    if (cpu_reset !== 1'b1 || lb.load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL start_in_idle: cpu_reset=%b ready=%b want 1/1",
               cpu_reset, lb.load_ready);
    end
  endtask

  task automatic test_basic();
    load_prog1();
    vectors++;
    if (prog_len !== 9'd3 || lb.load_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_len: len=%0d ready=%b want 3/0",
               prog_len, lb.load_ready);
    end
    pulse_start();
    vectors++;
    if (cpu_reset !== 1'b0 || cycle_count !== 32'd0) begin
      miscompares++;
      $display("FAIL basic_run: cpu_reset=%b cnt=%0d want 0/0",
               cpu_reset, cycle_count);
    end
    q.push_back(17'h01FEF); q.push_back(17'h1EE00); q.push_back(17'h1FFFF);
    for (int i = 0; i < 3; i++) begin
      pc = 17'(i);
      #1;
      e = q.pop_front();
      vectors++;
      if (instr !== e) begin
        miscompares++;
        $display("FAIL basic_instr pc=%0d: got %h want %h", i, instr, e);
      end
      tick();
    end
    vectors++;
    if (halted !== 1'b1 || cpu_reset !== 1'b1 || cycle_count !== 32'd3) begin
      miscompares++;
      $display("FAIL basic_halt: halted=%b cpu_reset=%b cnt=%0d want 1/1/3",
               halted, cpu_reset, cycle_count);
    end
    vectors++;
    if (instr !== 17'h0 || err_pc !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_post: instr=%h err_pc=%b want 0/0", instr, err_pc);
    end
  endtask

  task automatic test_partial();
    do_clear();
    send(8'h22, 0);
    send(8'h00, 1);
    vectors++;
    if (prog_len !== 9'd1) begin
      miscompares++;
      $display("FAIL partial_len: got %0d want 1", prog_len);
    end
    pulse_start();
    q.push_back(17'h00022); q.push_back(17'h1FFFF);
    for (int i = 0; i < 2; i++) begin
      pc = 17'(i);
      #1;
      e = q.pop_front();
      vectors++;
      if (instr !== e) begin
        miscompares++;
        $display("FAIL partial_instr pc=%0d: got %h want %h", i, instr, e);
      end
      tick();
    end
    vectors++;
    if (halted !== 1'b1 || err_pc !== 1'b1 || cycle_count !== 32'd2) begin
      miscompares++;
      $display("FAIL partial_halt: halted=%b err_pc=%b cnt=%0d want 1/1/2",
               halted, err_pc, cycle_count);
    end
  endtask

  task automatic test_overflow();
    int bad_ready;
    bad_ready = 0;
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < 3; b++) begin
        lb4.load_valid = 1'b1;
        lb4.load_data  = (b == 0) ? 8'(w + 1) : 8'h00;
        lb4.load_last  = (w == 4 && b == 2);
        #1;
        if (lb4.load_ready !== 1'b1) bad_ready++;
        tick();
      end
    end
    lb4.load_valid = 1'b0;
    lb4.load_last  = 1'b0;
    vectors++;
    if (bad_ready != 0) begin
      miscompares++;
      $display("FAIL ovf_ready: %0d bytes saw ready low, want 0", bad_ready);
    end
    vectors++;
    if (prog_len4 !== 3'd4 || err_overflow4 !== 1'b1 ||
        lb4.load_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_state: len=%0d ovf=%b ready=%b want 4/1/0",
               prog_len4, err_overflow4, lb4.load_ready);
    end
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) q.push_back(17'(i + 1));
    q.push_back(17'h1FFFF);
    for (int i = 0; i < 5; i++) begin
      pc4 = 17'(i);
      #1;
      e = q.pop_front();
      vectors++;
      if (instr4 !== e) begin
        miscompares++;
        $display("FAIL ovf_instr pc=%0d: got %h want %h", i, instr4, e);
      end
      tick();
    end
    vectors++;
    if (halted4 !== 1'b1 || err_pc4 !== 1'b1 || cycle_count4 !== 32'd5) begin
      miscompares++;
      $display("FAIL ovf_halt: halted=%b err_pc=%b cnt=%0d want 1/1/5",
               halted4, err_pc4, cycle_count4);
    end
  endtask

  task automatic test_reset_mid_load();
    do_clear();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    reset = 1'b0;
    #1;
    vectors++;
    if (prog_len !== 9'd0 || lb.load_ready !== 1'b1 || err_pc !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: len=%0d ready=%b err_pc=%b want 0/1/0",
               prog_len, lb.load_ready, err_pc);
    end
    tick();
    reset = 1'b1;
    tick();
    send(8'h01, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'hFF, 0); send(8'hFF, 0); send(8'h01, 1);
    vectors++;
    if (prog_len !== 9'd2) begin
      miscompares++;
      $display("FAIL rml_len: got %0d want 2", prog_len);
    end
    pulse_start();
    q.push_back(17'h00001); q.push_back(17'h1FFFF);
    for (int i = 0; i < 2; i++) begin
      pc = 17'(i);
      #1;
      e = q.pop_front();
      vectors++;
      if (instr !== e) begin
        miscompares++;
        $display("FAIL rml_instr pc=%0d: got %h want %h", i, instr, e);
      end
      tick();
    end
    vectors++;
    if (halted !== 1'b1 || cycle_count !== 32'd2 || err_pc !== 1'b0) begin
      miscompares++;
      $display("FAIL rml_halt: halted=%b cnt=%0d err_pc=%b want 1/2/0",
               halted, cycle_count, err_pc);
    end
  endtask

  task automatic test_clear_priority();
    pc = 17'd0;
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    vectors++;
    if (lb.load_ready !== 1'b1 || prog_len !== 9'd0 ||
        cpu_reset !== 1'b1 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_state: ready=%b len=%0d cpu_reset=%b halted=%b",
               lb.load_ready, prog_len, cpu_reset, halted);
    end
    vectors++;
    if (instr !== 17'h0 || cycle_count !== 32'd2) begin
      miscompares++;
      $display("FAIL clr_hold: instr=%h cnt=%0d want 0/2",
               instr, cycle_count);
    end
    clear = 1'b1;
    send(8'hAA, 1);
    clear = 1'b0;
    vectors++;
    if (lb.load_ready !== 1'b1 || prog_len !== 9'd0) begin
      miscompares++;
      $display("FAIL clr_vs_load: ready=%b len=%0d want 1/0",
               lb.load_ready, prog_len);
    end
  endtask

  task automatic test_back_to_back();
    load_prog1();
    for (int r = 0; r < 2; r++) begin
      pulse_start();
      vectors++;
      if (cycle_count !== 32'd0 || cpu_reset !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_start run%0d: cnt=%0d cpu_reset=%b want 0/0",
                 r, cycle_count, cpu_reset);
      end
      q.push_back(17'h01FEF); q.push_back(17'h1EE00); q.push_back(17'h1FFFF);
      for (int i = 0; i < 3; i++) begin
        pc = 17'(i);
        #1;
        e = q.pop_front();
        vectors++;
        if (instr !== e) begin
          miscompares++;
          $display("FAIL b2b_instr run%0d pc=%0d: got %h want %h",
                   r, i, instr, e);
        end
        tick();
      end
      vectors++;
      if (halted !== 1'b1 || cycle_count !== 32'd3 || prog_len !== 9'd3) begin
        miscompares++;
        $display("FAIL b2b_halt run%0d: halted=%b cnt=%0d len=%0d want 1/3/3",
                 r, halted, cycle_count, prog_len);
      end
    end
  endtask

  initial begin
    lb.load_valid = 1'b0; lb.load_data = 8'h00; lb.load_last = 1'b0;
    lb4.load_valid = 1'b0; lb4.load_data = 8'h00; lb4.load_last = 1'b0;
    clear = 1'b0; start = 1'b0; pc = 17'd0;
    clear4 = 1'b0; start4 = 1'b0; pc4 = 17'd0;
    test_reset();
    test_basic();
    test_partial();
    test_overflow();
    test_reset_mid_load();
    test_clear_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/asip_prog_sequencer.md
Name: asip_prog_sequencer

Overview:
Parametrised program loader and instruction sequencer for the single-cycle ASIP core. It assembles instruction words from a narrow byte-stream load port into an internal instruction store, then holds the core in reset until started. While running, it supplies `instr` combinationally from the core's `pc`. It detects a halt instruction or an out-of-range PC, stops the core, and reports the cycle count. It replaces the hand-driven per-instruction stimulus used to bring up the core with a reusable block that works at any word width and program depth.

Parameters:
INSTR_W, 17, instruction word width in bits
PC_W, 17, width of the core PC input
DEPTH, 256, instruction store depth in words
ADDR_W, 8, store address width; must be at least ceil(log2(DEPTH))
LOAD_W, 8, load-port byte width
NOP_INSTR, 17'h00000, word driven on `instr` whenever the block is not in RUN
HALT_INSTR, 17'h1FFFF, word that terminates execution
CNT_W, 32, cycle counter width

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
load_valid  input  1  load byte present
load_ready  output  1  block accepts a load byte this cycle
load_data  input  LOAD_W  load byte; little-endian within a word
load_last  input  1  marks the final byte of the program
clear  input  1  abort or discard the program; return to IDLE
start  input  1  begin or restart execution
pc  input  PC_W  program counter from the core
instr  output  INSTR_W  instruction to the core
cpu_reset  output  1  active-high hold for the core
halted  output  1  block is in HALT
prog_len  output  ADDR_W+1  number of words stored
cycle_count  output  CNT_W  core cycles spent in the last or current RUN
err_overflow  output  1  sticky; a word was dropped because the store was full
err_pc  output  1  sticky; the run ended on an out-of-range PC

Behaviour:
- Reset values: state=IDLE, load_ready=1, instr=NOP_INSTR, cpu_reset=1, halted=0, prog_len=0, cycle_count=0, err_overflow=0, err_pc=0, byte index=0.
- Store contents are not reset.
- Reset may arrive in any state; the block returns to IDLE immediately and clears all of the above.
- BPW = ceil(INSTR_W/LOAD_W). With the defaults BPW=3.
- Load handshake: a byte is transferred on any rising edge where load_valid && load_ready.
- load_ready=1 in IDLE and LOAD, 0 in all other states.
- Byte k of a word fills bits [k*LOAD_W +: LOAD_W]. Bits at or above INSTR_W are discarded.
- A word is written to store[prog_len] and prog_len increments when either:
  - byte BPW-1 is transferred, or
  - load_last is transferred. A partial word has its missing bytes zero-filled.
- If prog_len==DEPTH when a word completes, the word is dropped, err_overflow is set, and prog_len holds.
- States and transitions:
  - IDLE: the first transferred byte moves to LOAD. If that byte carries load_last, move directly to READY.
  - LOAD: a transferred byte with load_last moves to READY.
  - READY: start moves to RUN, and cycle_count is cleared on the same edge.
  - RUN:
    - cpu_reset=0 and instr=store[pc[ADDR_W-1:0]].
    - If pc >= prog_len, instr=HALT_INSTR and err_pc is set on the edge that leaves RUN.
    - cycle_count increments every RUN cycle and saturates at all-ones.
    - When instr==HALT_INSTR on a rising edge, move to HALT. The halting cycle is counted.
  - HALT: halted=1, cpu_reset=1. start moves to RUN with cycle_count cleared; the program is re-run unchanged.
- clear in any non-reset state:
  - Go to IDLE with prog_len=0, byte index=0, err_overflow=0, err_pc=0.
  - cycle_count holds its value until the next start.
- clear has priority over start and over a simultaneous load transfer.
- start is ignored in IDLE, LOAD and RUN.
- In every state except RUN: cpu_reset=1 and instr=NOP_INSTR.
- The instr read path is combinational from pc (zero latency), matching the single-cycle core. Store writes are synchronous.
- The core's first fetch occurs in the first RUN cycle at pc=0.

Test Plan:
1. Reset, then load bytes EF,1F,00 | 00,EE,01 | FF,FF,01 (the last byte with load_last), start, drive pc=0,1,2. Required: prog_len=3; instr=0x01FEF, then 0x1EE00, then 0x1FFFF; halted=1 on the next edge; cycle_count=3; cpu_reset rises with halted.
2. Load 2 bytes 22,00 with load_last on the second byte. Required: prog_len=1, store[0]=0x00022. After start with pc=1, instr=HALT_INSTR, halted=1, err_pc=1.
3. With DEPTH=4, load 5 full words. Required: prog_len=4, err_overflow=1, fifth word absent, load_ready stays 1 until load_last.
4. Assert reset low mid-LOAD after 4 bytes, then release and load 3 bytes 01,00,00 plus a halt word. Required: prog_len=2 and store[0]=0x00001, with no residue from the aborted load.
5. In HALT, assert start and clear on the same cycle. Required: state=IDLE, prog_len=0, cpu_reset=1, instr=NOP_INSTR, and cycle_count holds its previous value.
6. Run the program from scenario 1 twice using start from HALT. Required: cycle_count=3 after each run, and store contents are unchanged.
